// File: rtl/logic_rs.sv
// Reservation station for the 32-bit logic unit.
// Buffers issued logic instructions, snoops the CDB for pending operands and
// dispatches the oldest fully-ready entry into a registered valid/ready stage.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   issue_*               instruction from the issue stage (valid/ready)
//   cdb_*                 common data bus broadcast (tag 0 never matches)
//   ex_*                  registered dispatch to the logic unit (valid/ready)
//   busy_count            number of occupied entries
module logic_rs #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned TAG_W       = 3,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  logic [2:0]                         issue_opcode,
  input  logic [DATA_W-1:0]                  issue_vj,
  input  logic [TAG_W-1:0]                   issue_qj,
  input  logic [DATA_W-1:0]                  issue_vk,
  input  logic [TAG_W-1:0]                   issue_qk,
  input  logic [TAG_W-1:0]                   issue_dest,
  input  logic                               cdb_valid,
  input  logic [TAG_W-1:0]                   cdb_tag,
  input  logic [DATA_W-1:0]                  cdb_data,
  output logic                               ex_valid,
  input  logic                               ex_ready,
  output logic [2:0]                         ex_opcode,
  output logic [DATA_W-1:0]                  ex_x1,
  output logic [DATA_W-1:0]                  ex_x2,
  output logic [TAG_W-1:0]                   ex_dest,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   busy_count
);

  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  // Entry storage
  logic [NUM_ENTRIES-1:0] busy_q, busy_d;
  logic [2:0]             op_q   [NUM_ENTRIES];
  logic [2:0]             op_d   [NUM_ENTRIES];
  logic [DATA_W-1:0]      vj_q   [NUM_ENTRIES];
  logic [DATA_W-1:0]      vj_d   [NUM_ENTRIES];
  logic [DATA_W-1:0]      vk_q   [NUM_ENTRIES];
  logic [DATA_W-1:0]      vk_d   [NUM_ENTRIES];
  logic [TAG_W-1:0]       qj_q   [NUM_ENTRIES];
  logic [TAG_W-1:0]       qj_d   [NUM_ENTRIES];
  logic [TAG_W-1:0]       qk_q   [NUM_ENTRIES];
  logic [TAG_W-1:0]       qk_d   [NUM_ENTRIES];
  logic [TAG_W-1:0]       dest_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       dest_d [NUM_ENTRIES];
  logic [IDX_W-1:0]       rank_q [NUM_ENTRIES];
  logic [IDX_W-1:0]       rank_d [NUM_ENTRIES];

  // Dispatch register and occupancy
  logic              ex_valid_q, ex_valid_d;
  logic [2:0]        ex_op_q, ex_op_d;
  logic [DATA_W-1:0] ex_x1_q, ex_x1_d;
  logic [DATA_W-1:0] ex_x2_q, ex_x2_d;
  logic [TAG_W-1:0]  ex_dest_q, ex_dest_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_ENTRIES-1:0] rdy;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       sel_idx;
  logic [IDX_W-1:0]       sel_rank;
  logic                   sel_found;
  logic                   can_load;
  logic                   dispatch;
  logic                   issue_acc;
  logic                   cdb_hit_ok;
  logic                   x1_only;

  assign issue_ready = ~&busy_q;
  assign issue_acc   = issue_valid & issue_ready;
  assign can_load    = ~ex_valid_q | ex_ready;
  assign dispatch    = can_load & sel_found;
  assign cdb_hit_ok  = cdb_valid & (cdb_tag != '0);
  assign x1_only     = (issue_opcode == 3'd4) || (issue_opcode == 3'd6);

  // Lowest free index and oldest ready entry, both from registered state
  always_comb begin
    free_idx  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rank  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      rdy[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
      if (rdy[i] && (!sel_found || rank_q[i] < sel_rank)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_rank  = rank_q[i];
      end
    end
  end

  // Next state: CDB capture, dispatch/age update, allocation
  always_comb begin
    busy_d     = busy_q;
    op_d       = op_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    dest_d     = dest_q;
    rank_d     = rank_q;
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_x1_d    = ex_x1_q;
    ex_x2_d    = ex_x2_q;
    ex_dest_d  = ex_dest_q;
    cnt_d      = cnt_q + CNT_W'(issue_acc) - CNT_W'(dispatch);

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (busy_q[i] && cdb_hit_ok && qj_q[i] == cdb_tag) begin
        vj_d[i] = cdb_data;
        qj_d[i] = '0;
      end
      if (busy_q[i] && cdb_hit_ok && qk_q[i] == cdb_tag) begin
        vk_d[i] = cdb_data;
        qk_d[i] = '0;
      end
      if (dispatch && sel_idx == IDX_W'(i)) begin
        busy_d[i] = 1'b0;
      end else if (dispatch && busy_q[i] && rank_q[i] > sel_rank) begin
        rank_d[i] = rank_q[i] - IDX_W'(1);
      end
    end

    if (can_load) begin
      ex_valid_d = sel_found;
      if (sel_found) begin
        ex_op_d   = op_q[sel_idx];
        ex_x1_d   = vj_q[sel_idx];
        ex_x2_d   = vk_q[sel_idx];
        ex_dest_d = dest_q[sel_idx];
      end
    end

    // New entry is youngest: rank equals occupancy after this edge's dispatch
    if (issue_acc) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = issue_opcode;
      dest_d[free_idx] = issue_dest;
      rank_d[free_idx] = IDX_W'(cnt_q - CNT_W'(dispatch));
      vj_d[free_idx]   = issue_vj;
      qj_d[free_idx]   = issue_qj;
      vk_d[free_idx]   = issue_vk;
      qk_d[free_idx]   = issue_qk;
      if (cdb_hit_ok && issue_qj == cdb_tag) begin
        vj_d[free_idx] = cdb_data;
        qj_d[free_idx] = '0;
      end
      if (cdb_hit_ok && issue_qk == cdb_tag) begin
        vk_d[free_idx] = cdb_data;
        qk_d[free_idx] = '0;
      end
      if (x1_only) begin
        vk_d[free_idx] = '0;
        qk_d[free_idx] = '0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_x1_q    <= '0;
      ex_x2_q    <= '0;
      ex_dest_q  <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
        rank_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_x1_q    <= ex_x1_d;
      ex_x2_q    <= ex_x2_d;
      ex_dest_q  <= ex_dest_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_q[i]   <= op_d[i];
        vj_q[i]   <= vj_d[i];
        vk_q[i]   <= vk_d[i];
        qj_q[i]   <= qj_d[i];
        qk_q[i]   <= qk_d[i];
        dest_q[i] <= dest_d[i];
        rank_q[i] <= rank_d[i];
      end
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_opcode  = ex_op_q;
  assign ex_x1      = ex_x1_q;
  assign ex_x2      = ex_x2_q;
  assign ex_dest    = ex_dest_q;
  assign busy_count = cnt_q;

endmodule

// File: tb/tb_logic_rs.sv
// Testbench for logic_rs: directed scenarios followed by random traffic,
// all checked against an age-ordered queue model of the station.
module tb_logic_rs;

  localparam int N  = 4;
  localparam int TW = 3;
  localparam int DW = 32;
  localparam int CW = $clog2(N + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, issue_valid, issue_ready, cdb_valid, ex_valid, ex_ready;
  logic [2:0]    issue_opcode, ex_opcode;
  logic [DW-1:0] issue_vj, issue_vk, cdb_data, ex_x1, ex_x2;
  logic [TW-1:0] issue_qj, issue_qk, issue_dest, cdb_tag, ex_dest;
  logic [CW-1:0] busy_count;

  logic_rs #(.NUM_ENTRIES(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_vj(issue_vj), .issue_qj(issue_qj),
    .issue_vk(issue_vk), .issue_qk(issue_qk), .issue_dest(issue_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_x1(ex_x1), .ex_x2(ex_x2), .ex_dest(ex_dest), .busy_count(busy_count)
  );

  // Model: station contents as a queue, oldest first
  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] vj, vk;
    logic [TW-1:0] qj, qk, dest;
  } ent_t;

  ent_t          mq[$];
  logic          m_exv;
  logic [2:0]    m_op;
  logic [DW-1:0] m_x1, m_x2;
  logic [TW-1:0] m_dest;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int   sz;
    int   hit;
    ent_t e;
    sz = mq.size();
    if (!rst_n) begin
      mq.delete();
      m_exv = 1'b0; m_op = '0; m_x1 = '0; m_x2 = '0; m_dest = '0;
      return;
    end
    if (!m_exv || ex_ready) begin
      hit = -1;
      foreach (mq[i]) if (hit < 0 && mq[i].qj == 0 && mq[i].qk == 0) hit = i;
      m_exv = (hit >= 0);
      if (hit >= 0) begin
        m_op = mq[hit].op; m_x1 = mq[hit].vj; m_x2 = mq[hit].vk; m_dest = mq[hit].dest;
        mq.delete(hit);
      end
    end
    if (cdb_valid && cdb_tag != 0) begin
      foreach (mq[i]) begin
        if (mq[i].qj == cdb_tag) begin mq[i].vj = cdb_data; mq[i].qj = '0; end
        if (mq[i].qk == cdb_tag) begin mq[i].vk = cdb_data; mq[i].qk = '0; end
      end
    end
    if (issue_valid && sz < N) begin
      e.op = issue_opcode; e.dest = issue_dest;
      e.vj = issue_vj; e.qj = issue_qj; e.vk = issue_vk; e.qk = issue_qk;
      if (cdb_valid && cdb_tag != 0 && e.qj == cdb_tag) begin e.vj = cdb_data; e.qj = '0; end
      if (cdb_valid && cdb_tag != 0 && e.qk == cdb_tag) begin e.vk = cdb_data; e.qk = '0; end
      if (e.op == 3'd4 || e.op == 3'd6) begin e.vk = '0; e.qk = '0; end
      mq.push_back(e);
    end
  endtask

  task automatic check_all();
    chk("issue_ready", 64'(issue_ready), 64'(mq.size() < N));
    chk("busy_count", 64'(busy_count), 64'(mq.size()));
    chk("ex_valid", 64'(ex_valid), 64'(m_exv));
    if (m_exv) begin
      chk("ex_opcode", 64'(ex_opcode), 64'(m_op));
      chk("ex_x1", 64'(ex_x1), 64'(m_x1));
      chk("ex_x2", 64'(ex_x2), 64'(m_x2));
      chk("ex_dest", 64'(ex_dest), 64'(m_dest));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
  endtask

  task automatic iss(input logic [2:0] op, input logic [DW-1:0] vj, input logic [TW-1:0] qj,
                     input logic [DW-1:0] vk, input logic [TW-1:0] qk, input logic [TW-1:0] dest);
    issue_valid = 1'b1; issue_opcode = op; issue_dest = dest;
    issue_vj = vj; issue_qj = qj; issue_vk = vk; issue_qk = qk;
  endtask

  task automatic cdb(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
  endtask

  initial begin
    rst_n = 1'b0; ex_ready = 1'b1;
    iss(3'd0, '0, '0, '0, '0, 3'd1);
    cdb(3'd1, 32'h0);
    idle();
    step();
    step();
    chk("rst_ex_opcode", 64'(ex_opcode), 64'd0);
    chk("rst_ex_x1", 64'(ex_x1), 64'd0);
    chk("rst_ex_dest", 64'(ex_dest), 64'd0);
    rst_n = 1'b1;

    // AND with both operands present: visible after the second edge
    iss(3'd0, 32'hF0F0F0F0, 3'd0, 32'hFF00FF00, 3'd0, 3'd1);
    step();
    chk("t1_busy_after_issue", 64'(busy_count), 64'd1);
    idle();
    step();
    chk("t1_ex_valid", 64'(ex_valid), 64'd1);
    chk("t1_ex_x1", 64'(ex_x1), 64'hF0F0F0F0);
    chk("t1_ex_x2", 64'(ex_x2), 64'hFF00FF00);
    chk("t1_busy_after_disp", 64'(busy_count), 64'd0);
    step();

    // XOR waiting on tag 5, captured from the CDB two cycles later
    iss(3'd1, 32'h0, 3'd5, 32'h0000FFFF, 3'd0, 3'd2);
    step();
    idle();
    step();
    cdb(3'd5, 32'h12345678);
    step();
    chk("t2_not_early", 64'(ex_valid), 64'd0);
    idle();
    step();
    chk("t2_ex_valid", 64'(ex_valid), 64'd1);
    chk("t2_ex_x1", 64'(ex_x1), 64'h12345678);
    step();

    // Issue-time forwarding from a same-cycle broadcast
    iss(3'd3, 32'h0, 3'd3, 32'h7, 3'd0, 3'd3);
    cdb(3'd3, 32'hA5A5A5A5);
    step();
    idle();
    step();
    chk("t3_ex_valid", 64'(ex_valid), 64'd1);
    chk("t3_ex_x1", 64'(ex_x1), 64'hA5A5A5A5);
    step();

    // NEG ignores its k operand tag
    iss(3'd6, 32'h55, 3'd0, 32'h99, 3'd4, 3'd4);
    step();
    idle();
    step();
    chk("t4_ex_valid", 64'(ex_valid), 64'd1);
    chk("t4_ex_x2", 64'(ex_x2), 64'd0);
    step();

    // Back-pressure: fill the station, then drain in issue order
    ex_ready = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      iss(3'd7, 32'(d), 3'd0, ~32'(d), 3'd0, 3'(d));
      step();
    end
    chk("t5_full_ready", 64'(issue_ready), 64'd0);
    chk("t5_held_dest", 64'(ex_dest), 64'd1);
    iss(3'd0, 32'h1, 3'd0, 32'h1, 3'd0, 3'd6);
    step();
    chk("t5_full_ignored", 64'(busy_count), 64'd4);
    chk("t5_still_held", 64'(ex_dest), 64'd1);
    idle();
    ex_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t5_order", 64'(ex_dest), 64'(j + 2));
    end
    step();
    chk("t5_drained", 64'(ex_valid), 64'd0);

    // Younger ready entry overtakes an older one that captures too late
    ex_ready = 1'b0;
    iss(3'd0, 32'h1, 3'd0, 32'h2, 3'd0, 3'd7);
    step();
    iss(3'd1, 32'h0, 3'd6, 32'h3, 3'd0, 3'd5);
    step();
    iss(3'd2, 32'h4, 3'd0, 32'h5, 3'd0, 3'd4);
    step();
    idle();
    step();
    cdb(3'd6, 32'hDEADBEEF);
    ex_ready = 1'b1;
    step();
    chk("t6_b_first", 64'(ex_dest), 64'd4);
    idle();
    step();
    chk("t6_a_second", 64'(ex_dest), 64'd5);
    chk("t6_a_x1", 64'(ex_x1), 64'hDEADBEEF);

    // Reset in the middle of traffic
    iss(3'd0, 32'h9, 3'd0, 32'h9, 3'd0, 3'd1);
    step();
    ex_ready = 1'b0;
    iss(3'd0, 32'h8, 3'd2, 32'h8, 3'd0, 3'd2);
    step();
    rst_n = 1'b0;
    cdb(3'd2, 32'h1);
    step();
    chk("t7_rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("t7_rst_busy", 64'(busy_count), 64'd0);
    rst_n = 1'b1;
    ex_ready = 1'b1;
    idle();
    step();

    // Random traffic against the model
    for (int c = 0; c < 500; c++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      issue_valid  = ($urandom_range(0, 2) != 0);
      issue_opcode = 3'($urandom);
      issue_vj     = $urandom;
      issue_vk     = $urandom;
      issue_qj     = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom);
      issue_qk     = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom);
      issue_dest   = 3'($urandom_range(1, 7));
      cdb_valid    = ($urandom_range(0, 1) != 0);
      cdb_tag      = 3'($urandom);
      cdb_data     = $urandom;
      ex_ready     = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_rs.md
Name: logic_rs

Overview:
- Reservation station feeding the 32-bit logic unit in the Tomasulo core.
- Buffers up to NUM_ENTRIES logic instructions from the issue stage and snoops the common data bus (CDB) for pending source operands.
- Dispatches the oldest fully-ready entry (opcode, X1, X2, destination tag) through a registered valid/ready output into the logic unit and its result path.

Parameters:
NUM_ENTRIES, 4, number of station entries (2..8)
TAG_W, 3, producer tag width; tag 0 means "value present, no producer"
DATA_W, 32, operand width (matches logic unit X1/X2/Y)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
issue_valid  input  1  issue stage presents an instruction
issue_ready  output  1  at least one free entry; issue accepted when issue_valid && issue_ready
issue_opcode  input  3  logic unit opcode (0 AND, 1 XOR, 2 NAND, 3 OR, 4 NOT, 5 NOR, 6 NEG, 7 XNOR)
issue_vj  input  DATA_W  operand j value, valid when issue_qj == 0
issue_qj  input  TAG_W  producer tag for operand j
issue_vk  input  DATA_W  operand k value, valid when issue_qk == 0
issue_qk  input  TAG_W  producer tag for operand k
issue_dest  input  TAG_W  tag this instruction broadcasts; never 0
cdb_valid  input  1  CDB broadcast this cycle
cdb_tag  input  TAG_W  CDB producer tag
cdb_data  input  DATA_W  CDB value
ex_valid  output  1  dispatch register holds an instruction
ex_ready  input  1  logic unit / result path accepts it
ex_opcode  output  3  to logic unit opcode
ex_x1  output  DATA_W  to logic unit X1
ex_x2  output  DATA_W  to logic unit X2
ex_dest  output  TAG_W  destination tag travelling with the result
busy_count  output  clog2(NUM_ENTRIES+1)  number of occupied entries

Behaviour:
- Reset: synchronous on rising clk with rst_n low. Clears all busy bits, ex_valid, ex_opcode/ex_x1/ex_x2/ex_dest and busy_count to 0. issue_ready is 1 from the first cycle after reset. Reset mid-operation discards all entries and the dispatch register, and ignores the issue and CDB inputs that cycle.
- Entry fields: busy, op, vj, qj, vk, qk, dest, rank (age, 0 = oldest).
- issue_ready is combinational from the registered busy bits: 1 iff any entry is free. It does not anticipate a same-cycle dispatch.
- Allocation: an accepted issue writes the lowest-index free entry with rank = current busy_count minus any same-cycle dispatch.
- Opcodes 4 (NOT) and 6 (NEG) use only X1. For these, qk is stored as 0 and vk as 0 regardless of the inputs.
- Issue-time forwarding: if cdb_valid and issue_qj == cdb_tag and issue_qj != 0, store vj = cdb_data, qj = 0. Same rule for k.
- CDB capture: for every busy entry with qj == cdb_tag (qj != 0) while cdb_valid, latch vj = cdb_data and clear qj. Same rule for k. Both operands may capture from one broadcast.
- Eligibility: an entry is ready when busy, qj == 0 and qk == 0, evaluated on registered state. An entry made ready by this cycle's CDB capture becomes eligible next cycle.
- Dispatch: when !ex_valid || ex_ready, the ready entry with smallest rank is loaded into the ex_* register (ex_x1 = vj, ex_x2 = vk) and freed that edge. Every busy entry with larger rank decrements its rank.
- If nothing is ready, ex_valid falls after the ex_ready handshake.
- Back-pressure: while ex_valid && !ex_ready, ex_* are held stable and no entry dispatches.
- Latency: an instruction accepted at edge k with both operands present gives ex_valid after edge k+1, if the dispatch slot is free.
- Simultaneous issue + dispatch: both occur. busy_count is unchanged. A freed entry is reusable from the next cycle.
- Full: busy_count == NUM_ENTRIES drops issue_ready. issue_valid is ignored without side effects.
- CDB tags matching no entry are ignored. A CDB broadcast of tag 0 is ignored.

Test Plan:
- Reset, then issue AND vj=0xF0F0F0F0 vk=0xFF00FF00 qj=qk=0 dest=1 -> ex_valid after 2nd edge; ex_opcode=0, x1=0xF0F0F0F0, x2=0xFF00FF00, ex_dest=1; busy_count 1→0.
- Issue XOR qj=5 dest=2, then cdb_valid tag=5 data=0x12345678 two cycles later -> ex_x1=0x12345678 one cycle after capture, not earlier.
- Issue with qj=3 in the same cycle as cdb tag=3 data=0xA5A5A5A5 -> forwarded; ex_valid next cycle with x1=0xA5A5A5A5.
- Issue NEG (op 6) with qk=4 and no tag-4 broadcast -> dispatches anyway, ex_x2=0.
- Hold ex_ready=0 and issue 5 ready entries (NUM_ENTRIES=4) -> first held stable on ex_*; station fills to 4 with issue_ready=0. Release ex_ready -> dests emerge in issue order.
- Entries A (qj=6) then B (ready). Broadcast tag 6 while B waits behind a stall -> B dispatched before A. Deassert rst_n mid-stream -> ex_valid=0 and busy_count=0 the next cycle.
